// File: rtl/seg_scan.sv
// Scan driver for an 8-digit common-anode seven-segment display: one nibble per slot,
// active-low digit enables, frame-aligned value commits, guard time and leading-zero blanking.
module seg_scan #(
   parameter int CLK_DIV = 50000,
   parameter int GUARD   = 500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] data_in,
   input  logic        blank_lz,
   output logic [3:0]  digit_val,
   output logic [7:0]  dig,
   output logic        frame_start
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [31:0]   disp_q, disp_d;
   logic [31:0]   pend_q, pend_d;
   logic          pend_v_q, pend_v_d;
   logic          blz_q, blz_d;

   logic          tick;
   logic          commit;
   logic [4:0]    nib_sh;
   logic [31:0]   upper;
   logic          blank;
   logic          in_guard;

   assign tick   = (cnt_q == CNT_MAX);
   // Commit only at the frame boundary, using the pending value as it stood before this edge.
   assign commit = tick && (idx_q == 3'd7) && pend_v_q;

   always_comb begin
      cnt_d    = tick ? '0 : cnt_q + 1'b1;
      idx_d    = tick ? idx_q + 3'd1 : idx_q;
      disp_d   = commit ? pend_q : disp_q;
      pend_d   = load ? data_in : pend_q;
      pend_v_d = load | (pend_v_q & ~commit);
      blz_d    = blank_lz;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         idx_q    <= 3'd0;
         disp_q   <= 32'h0;
         pend_q   <= 32'h0;
         pend_v_q <= 1'b0;
         blz_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         disp_q   <= disp_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         blz_q    <= blz_d;
      end
   end

   generate
      if (GUARD == 0) begin : g_noguard
         assign in_guard = 1'b0;
      end else begin : g_guard
         assign in_guard = (cnt_q < CW'(GUARD));
      end
   endgenerate

   // A digit is a leading zero when it and every digit to its left are zero.
   assign nib_sh = {idx_q, 2'b00};
   assign upper  = disp_q >> nib_sh;
   assign blank  = blz_q && (idx_q != 3'd0) && (upper == 32'h0);

   assign digit_val   = upper[3:0];
   assign dig         = (in_guard || blank) ? 8'hFF : ~(8'b1 << idx_q);
   assign frame_start = (idx_q == 3'd0) && (cnt_q == '0);

endmodule
